// File: rtl/dual_branch_predictor_if.sv
// rtl/dual_branch_predictor_if.sv - fetch lookup and execute training bundle for dual_branch_predictor
interface dual_branch_predictor_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6
);
  logic [PC_W-1:0]  pcF1;
  logic [PC_W-1:0]  pcF2;
  logic             predictF1;
  logic             predictF2;
  logic [IDX_W-1:0] idxF1;
  logic [IDX_W-1:0] idxF2;
  logic             branchE1;
  logic             branchE2;
  logic             takenE1;
  logic             takenE2;
  logic [IDX_W-1:0] idxE1;
  logic [IDX_W-1:0] idxE2;
  logic             mispredE1;

  modport master (
    output pcF1, pcF2,
    input  predictF1, predictF2, idxF1, idxF2,
    output branchE1, branchE2, takenE1, takenE2, idxE1, idxE2, mispredE1
  );

  modport slave (
    input  pcF1, pcF2,
    output predictF1, predictF2, idxF1, idxF2,
    input  branchE1, branchE2, takenE1, takenE2, idxE1, idxE2, mispredE1
  );
endinterface

// File: rtl/dual_branch_predictor.sv
// rtl/dual_branch_predictor.sv - dual-slot 2-bit saturating-counter BHT with combinational lookup.
// Define GSHARE_PREDICTOR_EN to XOR a non-speculative global history register into the fetch index.
module dual_branch_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  dual_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       ctr_q [ENTRIES];
  logic [1:0]       ctr_d [ENTRIES];
  logic             upd1;
  logic             upd2;
  logic [IDX_W-1:0] pc_idx1;
  logic [IDX_W-1:0] pc_idx2;
  logic             unused_pc_bits;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Slot 2 sits behind slot 1 in program order, so a slot-1 mispredict flushes it.
  assign upd1 = bp.branchE1;
  assign upd2 = bp.branchE2 & ~bp.mispredE1;

  assign pc_idx1 = bp.pcF1[IDX_W+1:2];
  assign pc_idx2 = bp.pcF2[IDX_W+1:2];

  assign unused_pc_bits = ^{bp.pcF1[PC_W-1:IDX_W+2], bp.pcF1[1:0],
                            bp.pcF2[PC_W-1:IDX_W+2], bp.pcF2[1:0]};

`ifdef GSHARE_PREDICTOR_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd1) begin
      ghr_d = {ghr_d[IDX_W-2:0], bp.takenE1};
    end
    if (upd2) begin
      ghr_d = {ghr_d[IDX_W-2:0], bp.takenE2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign bp.idxF1 = pc_idx1 ^ ghr_q;
  assign bp.idxF2 = pc_idx2 ^ ghr_q;
`else
  assign bp.idxF1 = pc_idx1;
  assign bp.idxF2 = pc_idx2;
`endif

  assign bp.predictF1 = ctr_q[bp.idxF1][1];
  assign bp.predictF2 = ctr_q[bp.idxF2][1];

  // Slot 2 reads ctr_d so a same-index pair chains as sat(sat(c, t1), t2).
  always_comb begin
    ctr_d = ctr_q;
    if (upd1) begin
      ctr_d[bp.idxE1] = sat_step(ctr_q[bp.idxE1], bp.takenE1);
    end
    if (upd2) begin
      ctr_d[bp.idxE2] = sat_step(ctr_d[bp.idxE2], bp.takenE2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end
endmodule

// File: tb/tb_dual_branch_predictor.sv
// tb/tb_dual_branch_predictor.sv - randomized and directed checks of dual_branch_predictor against a table model
module tb_dual_branch_predictor;
  localparam int PC_W  = 32;
  localparam int IDX_W = 6;
  localparam int ENT   = 64;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ctr_m [ENT];
  int   ghr_m;

  dual_branch_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bp_if ();

  dual_branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int c, input bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic int hist();
`ifdef GSHARE_PREDICTOR_EN
    return ghr_m;
`else
    return 0;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] pc);
    return (int'(pc >> 2) & (ENT - 1)) ^ hist();
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    logic [31:0] hi;
    hi = $urandom & 32'hFFFF_FF00;
    return hi | 32'(((idx ^ hist()) & (ENT - 1)) * 4) | 32'($urandom_range(0, 3));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) ctr_m[i] = 1;
    ghr_m = 0;
  endfunction

  function automatic void model_train(input bit b1, input bit t1, input int i1,
                                      input bit b2, input bit t2, input int i2, input bit m1);
    if (b1) begin
      ctr_m[i1] = sat(ctr_m[i1], t1);
      ghr_m     = ((ghr_m * 2) + int'(t1)) % ENT;
    end
    if (b2 && !m1) begin
      ctr_m[i2] = sat(ctr_m[i2], t2);
      ghr_m     = ((ghr_m * 2) + int'(t2)) % ENT;
    end
  endfunction

  task automatic clear_exec();
    bp_if.branchE1  = 1'b0;
    bp_if.branchE2  = 1'b0;
    bp_if.takenE1   = 1'b0;
    bp_if.takenE2   = 1'b0;
    bp_if.idxE1     = '0;
    bp_if.idxE2     = '0;
    bp_if.mispredE1 = 1'b0;
  endtask

  task automatic train(input bit b1, input bit t1, input int i1,
                       input bit b2, input bit t2, input int i2, input bit m1);
    bp_if.branchE1  = b1;
    bp_if.takenE1   = t1;
    bp_if.idxE1     = i1[IDX_W-1:0];
    bp_if.branchE2  = b2;
    bp_if.takenE2   = t2;
    bp_if.idxE2     = i2[IDX_W-1:0];
    bp_if.mispredE1 = m1;
    @(posedge clk);
    model_train(b1, t1, i1, b2, t2, i2, m1);
    #1;
    clear_exec();
  endtask

  task automatic check_dir(input int idx, input bit exp, input string name);
    @(negedge clk);
    bp_if.pcF1 = pc_for(idx);
    bp_if.pcF2 = pc_for(idx);
    #1;
    total++;
    if (bp_if.predictF1 !== exp || bp_if.predictF2 !== exp) begin
      bad++;
      $display("FAIL %s: idx=%0d predictF1=%0b predictF2=%0b expected=%0b",
               name, idx, bp_if.predictF1, bp_if.predictF2, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] pc;
    rst_n = 1'b0;
    bp_if.pcF1 = '0;
    bp_if.pcF2 = '0;
    clear_exec();
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      bp_if.pcF1 = $urandom;
      bp_if.pcF2 = $urandom;
      #1;
      total++;
      if (bp_if.predictF1 !== 1'b0 || bp_if.predictF2 !== 1'b0) begin
        bad++;
        $display("FAIL reset_predict: predictF1=%0b predictF2=%0b expected=0",
                 bp_if.predictF1, bp_if.predictF2);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    bp_if.pcF1 = 32'h40;
    pc = $urandom;
    bp_if.pcF2 = pc;
    #1;
    total++;
    if (bp_if.idxF1 !== 6'h10 || bp_if.predictF1 !== 1'b0 || bp_if.predictF2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_idx: idxF1=%0h predictF1=%0b predictF2=%0b expected idx=10 pred=0",
               bp_if.idxF1, bp_if.predictF1, bp_if.predictF2);
    end
    total++;
    if (int'(bp_if.idxF2) !== model_idx(pc)) begin
      bad++;
      $display("FAIL reset_idxF2: idxF2=%0h expected=%0h", bp_if.idxF2, model_idx(pc));
    end
  endtask

  task automatic test_single_training();
    train(1, 1, 16, 0, 0, 0, 0);
    check_dir(16, 1'b1, "train_T_once");
    train(1, 0, 16, 0, 0, 0, 0);
    check_dir(16, 1'b0, "train_NT_once");
    train(1, 0, 16, 0, 0, 0, 0);
    train(0, 0, 0, 1, 0, 16, 0);
    check_dir(16, 1'b0, "train_NT_floor");
    train(1, 1, 16, 0, 0, 0, 0);
    check_dir(16, 1'b0, "floor_no_wrap");
    train(1, 1, 16, 0, 0, 0, 0);
    check_dir(16, 1'b1, "floor_recover");
  endtask

  task automatic test_same_index_pair();
    train(1, 1, 5, 1, 1, 5, 0);
    check_dir(5, 1'b1, "pair_TT");
    train(1, 0, 5, 1, 0, 5, 0);
    check_dir(5, 1'b0, "pair_NTNT");
    train(1, 1, 5, 0, 0, 0, 0);
    check_dir(5, 1'b1, "pair_NTNT_lands_01");
  endtask

  task automatic test_mispredict_kill();
    train(1, 0, 8, 1, 1, 7, 1);
    check_dir(7, 1'b0, "mispred_kills_slot2");
    train(0, 0, 0, 1, 1, 7, 0);
    check_dir(7, 1'b1, "slot2_trains_alone");
  endtask

  task automatic test_saturation_async_reset();
    for (int k = 0; k < 5; k++) train(1, 1, 3, 0, 0, 0, 0);
    check_dir(3, 1'b1, "sat_top");
    train(1, 0, 3, 0, 0, 0, 0);
    check_dir(3, 1'b1, "sat_top_one_NT");
    @(posedge clk);
    #1;
    bp_if.branchE1 = 1'b1;
    bp_if.takenE1  = 1'b0;
    bp_if.idxE1    = 6'd3;
    #2;
    rst_n = 1'b0;
    model_reset();
    bp_if.pcF1 = pc_for(3);
    bp_if.pcF2 = pc_for(5);
    #1;
    total++;
    if (bp_if.predictF1 !== 1'b0 || bp_if.predictF2 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: predictF1=%0b predictF2=%0b expected=0",
               bp_if.predictF1, bp_if.predictF2);
    end
    @(posedge clk);
    #1;
    clear_exec();
    @(negedge clk);
    rst_n = 1'b1;
    train(1, 1, 3, 0, 0, 0, 0);
    check_dir(3, 1'b1, "reset_discards_pending");
  endtask

  task automatic test_history_index();
    do_reset();
    train(1, 1, 9, 1, 0, 20, 0);
    @(negedge clk);
    bp_if.pcF1 = 32'h40;
    #1;
    total++;
`ifdef GSHARE_PREDICTOR_EN
    if (bp_if.idxF1 !== 6'h12) begin
      bad++;
      $display("FAIL gshare_idx: idxF1=%0h expected=12", bp_if.idxF1);
    end
`else
    if (bp_if.idxF1 !== 6'h10) begin
      bad++;
      $display("FAIL bimodal_idx: idxF1=%0h expected=10", bp_if.idxF1);
    end
`endif
  endtask

  task automatic test_random();
    bit b1, t1, b2, t2, m1;
    int i1, i2, e1, e2;
    logic [31:0] p1, p2;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      b1 = ($urandom_range(0, 9) < 6);
      b2 = ($urandom_range(0, 9) < 6);
      t1 = $urandom_range(0, 1);
      t2 = $urandom_range(0, 1);
      m1 = ($urandom_range(0, 3) == 0);
      i1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ENT - 1)) : int'($urandom_range(0, 7));
      i2 = ($urandom_range(0, 1) == 0) ? i1 : int'($urandom_range(0, 7));
      p1 = ($urandom_range(0, 1) == 0) ? pc_for(i1) : $urandom;
      p2 = ($urandom_range(0, 1) == 0) ? pc_for(i2) : $urandom;
      bp_if.pcF1      = p1;
      bp_if.pcF2      = p2;
      bp_if.branchE1  = b1;
      bp_if.takenE1   = t1;
      bp_if.idxE1     = i1[IDX_W-1:0];
      bp_if.branchE2  = b2;
      bp_if.takenE2   = t2;
      bp_if.idxE2     = i2[IDX_W-1:0];
      bp_if.mispredE1 = m1;
      #1;
      e1 = model_idx(p1);
      e2 = model_idx(p2);
      total++;
      if (int'(bp_if.idxF1) !== e1 || int'(bp_if.idxF2) !== e2) begin
        bad++;
        $display("FAIL rand_idx n=%0d: idxF1=%0h idxF2=%0h expected %0h %0h",
                 n, bp_if.idxF1, bp_if.idxF2, e1, e2);
      end
      total++;
      if (bp_if.predictF1 !== (ctr_m[e1] >= 2) || bp_if.predictF2 !== (ctr_m[e2] >= 2)) begin
        bad++;
        $display("FAIL rand_predict n=%0d: predictF1=%0b predictF2=%0b expected %0b %0b",
                 n, bp_if.predictF1, bp_if.predictF2, ctr_m[e1] >= 2, ctr_m[e2] >= 2);
      end
      @(posedge clk);
      model_train(b1, t1, i1, b2, t2, i2, m1);
      #1;
      clear_exec();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_training();
    test_same_index_pair();
    test_mispredict_kill();
    test_saturation_async_reset();
    test_history_index();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
